// File: rtl/exu_muldiv_if.sv
// Request/result handshake bundle between the EXU decode stage, the iterative
// multiply/divide unit and writeback.
interface exu_muldiv_if #(
   parameter int unsigned XLEN        = 32,
   parameter int unsigned RFIDX_WIDTH = 5
);
   logic                   i_valid;
   logic                   i_ready;
   logic [7:0]             i_op;
   logic [XLEN-1:0]        i_rs1;
   logic [XLEN-1:0]        i_rs2;
   logic [RFIDX_WIDTH-1:0] i_rdidx;
   logic                   i_flush;
   logic                   o_valid;
   logic                   o_ready;
   logic [XLEN-1:0]        o_result;
   logic [RFIDX_WIDTH-1:0] o_rdidx;
   logic                   o_busy;

   modport master (
      output i_valid, i_op, i_rs1, i_rs2, i_rdidx, i_flush, o_ready,
      input  i_ready, o_valid, o_result, o_rdidx, o_busy
   );

   modport slave (
      input  i_valid, i_op, i_rs1, i_rs2, i_rdidx, i_flush, o_ready,
      output i_ready, o_valid, o_result, o_rdidx, o_busy
   );
endinterface

// File: rtl/exu_muldiv.sv
// Iterative RV32M multiply/divide unit: one bit per cycle over magnitudes,
// sign fix-up at the end, result held on a valid/ready port until taken.
module exu_muldiv #(
   parameter int unsigned XLEN        = 32,
   parameter int unsigned RFIDX_WIDTH = 5
) (
   input  logic        clk,
   input  logic        rst_n,
   exu_muldiv_if.slave bus
);
   localparam int unsigned CW = $clog2(XLEN);

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;
   typedef enum logic [2:0] {
      OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
   } op_e;

   state_e                 state, state_nxt;
   op_e                    op_dec, op_q;
   logic [CW-1:0]          cnt;
   logic [RFIDX_WIDTH-1:0] rdidx_q;
   logic [XLEN-1:0]        opnd_q, result_q;
   logic [2*XLEN-1:0]      acc;
   logic                   neg_q, neg_rem_q, valid_q;

   logic                   is_mul, is_rem, s1_signed, s2_signed, sign1, sign2;
   logic                   div_zero, div_ovf, accept, handshake, rem_ge;
   logic [XLEN-1:0]        mag1, mag2, special_res;
   logic [XLEN:0]          mul_sum, rem_shift;
   logic [2*XLEN-1:0]      prod_fix;
   logic [XLEN-1:0]        quo_fix, rem_fix, result_fix;

   // Anything not exactly one-hot falls back to a plain multiply.
   always_comb begin
      case (bus.i_op)
         8'h01:   op_dec = OP_MUL;
         8'h02:   op_dec = OP_MULH;
         8'h04:   op_dec = OP_MULHSU;
         8'h08:   op_dec = OP_MULHU;
         8'h10:   op_dec = OP_DIV;
         8'h20:   op_dec = OP_DIVU;
         8'h40:   op_dec = OP_REM;
         8'h80:   op_dec = OP_REMU;
         default: op_dec = OP_MUL;
      endcase
   end

   always_comb begin
      is_mul    = op_dec inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
      is_rem    = op_dec inside {OP_REM, OP_REMU};
      s1_signed = op_dec inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
      s2_signed = op_dec inside {OP_MULH, OP_DIV, OP_REM};
      sign1     = s1_signed & bus.i_rs1[XLEN-1];
      sign2     = s2_signed & bus.i_rs2[XLEN-1];
      mag1      = sign1 ? -bus.i_rs1 : bus.i_rs1;
      mag2      = sign2 ? -bus.i_rs2 : bus.i_rs2;
      div_zero  = ~is_mul & (bus.i_rs2 == '0);
      div_ovf   = (op_dec == OP_DIV || op_dec == OP_REM) &&
                  (bus.i_rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (bus.i_rs2 == '1);
      special_res = '0;
      if (div_zero)     special_res = is_rem ? bus.i_rs1 : '1;
      else if (div_ovf) special_res = is_rem ? '0 : bus.i_rs1;
   end

   assign accept    = bus.i_valid & (state == IDLE) & ~bus.i_flush;
   assign handshake = valid_q & bus.o_ready;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = (div_zero | div_ovf) ? DONE : CALC;
         CALC:    if (cnt == CW'(XLEN-1)) state_nxt = FIX;
         FIX:     state_nxt = DONE;
         DONE:    if (handshake) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (bus.i_flush) state_nxt = IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // acc is {product hi, multiplier} for mul and {partial remainder, dividend/quotient} for div.
   always_comb begin
      mul_sum   = acc[0] ? ({1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, opnd_q})
                         : {1'b0, acc[2*XLEN-1:XLEN]};
      rem_shift = acc[2*XLEN-1:XLEN-1];
      rem_ge    = rem_shift >= {1'b0, opnd_q};
      prod_fix  = neg_q ? -acc : acc;
      quo_fix   = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
      rem_fix   = neg_rem_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
      case (op_q)
         OP_MUL:                       result_fix = prod_fix[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: result_fix = prod_fix[2*XLEN-1:XLEN];
         OP_DIV, OP_DIVU:              result_fix = quo_fix;
         default:                      result_fix = rem_fix;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q      <= OP_MUL;
         rdidx_q   <= '0;
         opnd_q    <= '0;
         acc       <= '0;
         cnt       <= '0;
         neg_q     <= 1'b0;
         neg_rem_q <= 1'b0;
         result_q  <= '0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               op_q      <= op_dec;
               rdidx_q   <= bus.i_rdidx;
               neg_q     <= sign1 ^ sign2;
               neg_rem_q <= sign1;
               cnt       <= '0;
               opnd_q    <= is_mul ? mag1 : mag2;
               acc       <= {{XLEN{1'b0}}, (is_mul ? mag2 : mag1)};
               if (div_zero | div_ovf) result_q <= special_res;
            end
            CALC: begin
               cnt <= cnt + CW'(1);
               if (op_q inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU})
                  acc <= {mul_sum, acc[XLEN-1:1]};
               else
                  acc <= {(rem_ge ? XLEN'(rem_shift - {1'b0, opnd_q}) : rem_shift[XLEN-1:0]),
                          acc[XLEN-2:0], rem_ge};
            end
            FIX: if (!bus.i_flush) result_q <= result_fix;
            default: ;
         endcase
      end
   end

   // o_valid lags DONE entry by one edge; it drops on handshake or flush.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) valid_q <= 1'b0;
      else        valid_q <= (state == DONE) & ~handshake & ~bus.i_flush;
   end

   assign bus.i_ready  = (state == IDLE);
   assign bus.o_busy   = (state != IDLE);
   assign bus.o_valid  = valid_q;
   assign bus.o_result = result_q;
   assign bus.o_rdidx  = rdidx_q;
endmodule

// File: tb/tb_exu_muldiv.sv
// Directed-vector bench for the iterative multiply/divide unit.
module tb_exu_muldiv;
   localparam int unsigned XLEN = 32;
   localparam int unsigned RW   = 5;

   localparam logic [7:0] MUL    = 8'h01;
   localparam logic [7:0] MULH   = 8'h02;
   localparam logic [7:0] MULHSU = 8'h04;
   localparam logic [7:0] MULHU  = 8'h08;
   localparam logic [7:0] DIV    = 8'h10;
   localparam logic [7:0] DIVU   = 8'h20;
   localparam logic [7:0] REM    = 8'h40;
   localparam logic [7:0] REMU   = 8'h80;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;

   exu_muldiv_if #(.XLEN(XLEN), .RFIDX_WIDTH(RW)) dif ();

   exu_muldiv #(.XLEN(XLEN), .RFIDX_WIDTH(RW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (dif.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic send(input string tag, input logic [7:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd);
      @(negedge clk);
      check({tag, "_rdy"}, 32'(dif.i_ready), 32'd1);
      dif.i_valid = 1'b1;
      dif.i_op    = op;
      dif.i_rs1   = a;
      dif.i_rs2   = b;
      dif.i_rdidx = rd;
      @(posedge clk);
      #1;
      dif.i_valid = 1'b0;
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      while (dif.o_valid !== 1'b1 && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic run_op(input string tag, input logic [7:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd,
                         input logic [31:0] exp, input int exp_lat);
      int lat;
      send(tag, op, a, b, rd);
      wait_valid(lat);
      check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      check({tag, "_res"}, dif.o_result, exp);
      check({tag, "_rd"}, 32'(dif.o_rdidx), 32'(rd));
      @(posedge clk);
      #1;
      check({tag, "_idle"}, 32'({dif.o_valid, dif.i_ready}), 32'h1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int lat;
      int nv;
      dif.i_valid = 1'b0;
      dif.i_op    = '0;
      dif.i_rs1   = '0;
      dif.i_rs2   = '0;
      dif.i_rdidx = '0;
      dif.i_flush = 1'b0;
      dif.o_ready = 1'b1;

      repeat (2) @(posedge clk);
      #1;
      check("rst_ready",  32'(dif.i_ready), 32'd1);
      check("rst_valid",  32'(dif.o_valid), 32'd0);
      check("rst_busy",   32'(dif.o_busy),  32'd0);
      check("rst_result", dif.o_result,     32'd0);
      check("rst_rdidx",  32'(dif.o_rdidx), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run_op("mul_7x6",      MUL,    32'd7,        32'd6,        5'd5,  32'd42,       34);
      run_op("mul_neg3x5",   MUL,    32'hFFFFFFFD, 32'd5,        5'd6,  32'hFFFFFFF1, 34);
      run_op("mulh_m1xm1",   MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  32'h00000000, 34);
      run_op("mulhu_max",    MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8,  32'hFFFFFFFE, 34);
      run_op("mulhsu_m1x2",  MULHSU, 32'hFFFFFFFF, 32'd2,        5'd9,  32'hFFFFFFFF, 34);
      run_op("mulh_minsq",   MULH,   32'h80000000, 32'h80000000, 5'd10, 32'h40000000, 34);
      run_op("bad_onehot",   8'h03,  32'd5,        32'd5,        5'd11, 32'd25,       34);
      run_op("div_m7_2",     DIV,    32'hFFFFFFF9, 32'd2,        5'd12, 32'hFFFFFFFD, 34);
      run_op("rem_m7_2",     REM,    32'hFFFFFFF9, 32'd2,        5'd13, 32'hFFFFFFFF, 34);
      run_op("divu_100_7",   DIVU,   32'd100,      32'd7,        5'd14, 32'd14,       34);
      run_op("remu_100_7",   REMU,   32'd100,      32'd7,        5'd15, 32'd2,        34);
      run_op("div_min_2",    DIV,    32'h80000000, 32'd2,        5'd16, 32'hC0000000, 34);
      run_op("divu_by0",     DIVU,   32'd1234,     32'd0,        5'd17, 32'hFFFFFFFF, 1);
      run_op("rem_13_0",     REM,    32'd13,       32'd0,        5'd18, 32'd13,       1);
      run_op("div_ovf",      DIV,    32'h80000000, 32'hFFFFFFFF, 5'd19, 32'h80000000, 1);
      run_op("rem_ovf",      REM,    32'h80000000, 32'hFFFFFFFF, 5'd20, 32'd0,        1);

      send("flush", MUL, 32'd12345, 32'd678, 5'd3);
      repeat (10) @(posedge clk);
      @(negedge clk);
      dif.i_flush = 1'b1;
      dif.i_valid = 1'b1;
      dif.i_op    = MUL;
      dif.i_rs1   = 32'd2;
      dif.i_rs2   = 32'd2;
      dif.i_rdidx = 5'd7;
      @(posedge clk);
      #1;
      check("flush_state", 32'({dif.o_busy, dif.i_ready, dif.o_valid}), 32'h2);
      dif.i_flush = 1'b0;
      dif.i_valid = 1'b0;
      nv = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (dif.o_valid === 1'b1 || dif.o_busy === 1'b1) nv++;
      end
      check("flush_quiet", 32'(nv), 32'd0);
      run_op("after_flush", MUL, 32'd3, 32'd3, 5'd4, 32'd9, 34);

      dif.o_ready = 1'b0;
      send("stall", MUL, 32'd11, 32'd13, 5'd9);
      wait_valid(lat);
      check("stall_lat", 32'(lat), 32'd34);
      for (int i = 0; i < 5; i++) begin
         check("stall_hold", 32'({dif.o_valid, dif.i_ready}), 32'h2);
         check("stall_res",  dif.o_result,     32'd143);
         check("stall_rd",   32'(dif.o_rdidx), 32'd9);
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      dif.o_ready = 1'b1;
      @(posedge clk);
      #1;
      check("stall_release", 32'({dif.o_valid, dif.i_ready}), 32'h1);
      @(posedge clk);
      #1;
      check("stall_single", 32'({dif.o_valid, dif.o_busy}), 32'h0);

      dif.o_ready = 1'b0;
      send("flush_done", MUL, 32'd2, 32'd2, 5'd1);
      wait_valid(lat);
      check("flush_done_lat", 32'(lat), 32'd34);
      @(negedge clk);
      dif.i_flush = 1'b1;
      dif.o_ready = 1'b1;
      @(posedge clk);
      #1;
      check("flush_done_idle", 32'({dif.o_valid, dif.i_ready}), 32'h1);
      dif.i_flush = 1'b0;

      send("midrst", MUL, 32'd5, 32'd5, 5'd2);
      repeat (5) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_state",  32'({dif.o_busy, dif.o_valid, dif.i_ready}), 32'h1);
      check("midrst_result", dif.o_result,     32'd0);
      check("midrst_rdidx",  32'(dif.o_rdidx), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op("post_rst", DIVU, 32'd100, 32'd7, 5'd21, 32'd14, 34);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
